// File: rtl/encoder8to3_irq.sv
// Registered 8-to-3 priority encoder with request latching and grant/ack handshake.
// Optional rising-edge request capture with overrun detection: ENC8TO3_EDGE_CAPTURE_EN.
module encoder8to3_irq (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] y,
  output logic       valid,
  output logic [7:0] pending,
  output logic       overrun
);

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [IDX_W-1:0]   r_y;
  logic [IDX_W-1:0]   w_y_nxt;
  logic               r_valid;
  logic               w_valid_nxt;
  logic [N_REQ-1:0]   r_pending;
  logic [N_REQ-1:0]   w_pending_nxt;
  logic               r_overrun;
  logic               w_overrun_nxt;
  logic [N_REQ-1:0]   w_cap;
  logic [N_REQ-1:0]   w_clr;
  logic               w_ovr_hit;

  // Index of the highest set bit; ascending scan lets higher bits overwrite lower ones.
  function automatic logic [IDX_W-1:0] f_top(input logic [N_REQ-1:0] v);
    logic [IDX_W-1:0] idx;
    idx = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      if (v[i]) idx = IDX_W'(i);
    end
    return idx;
  endfunction

`ifdef ENC8TO3_EDGE_CAPTURE_EN
  logic [N_REQ-1:0] r_req_hist;

  // History resets to 0 so a request held through reset release counts as an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_req_hist <= '0;
    else        r_req_hist <= req;
  end

  assign w_cap     = req & ~r_req_hist;
  assign w_ovr_hit = |(w_cap & r_pending);
`else
  assign w_cap     = req;
  assign w_ovr_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_y       <= '0;
      r_valid   <= 1'b0;
      r_pending <= '0;
      r_overrun <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_y       <= w_y_nxt;
      r_valid   <= w_valid_nxt;
      r_pending <= w_pending_nxt;
      r_overrun <= w_overrun_nxt;
    end
  end

  // Grant is locked while in GRANT; only ack releases it. New captures beat the ack clear.
  always_comb begin
    w_state_nxt = r_state;
    w_y_nxt     = r_y;
    w_valid_nxt = r_valid;
    w_clr       = '0;
    case (r_state)
      IDLE: begin
        if (|r_pending) begin
          w_state_nxt = GRANT;
          w_y_nxt     = f_top(r_pending);
          w_valid_nxt = 1'b1;
        end
      end
      GRANT: begin
        if (ack) begin
          w_clr       = N_REQ'(1) << r_y;
          w_state_nxt = IDLE;
          w_valid_nxt = 1'b0;
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    w_pending_nxt = (r_pending & ~w_clr) | w_cap;
    w_overrun_nxt = r_overrun | w_ovr_hit;
  end

  assign y       = r_y;
  assign valid   = r_valid;
  assign pending = r_pending;
  assign overrun = r_overrun;

endmodule

// File: tb/tb_encoder8to3_irq.sv
// Self-checking bench for encoder8to3_irq: directed scenarios plus randomized traffic
// against an event-level reference model; follows ENC8TO3_EDGE_CAPTURE_EN like the DUT.
module tb_encoder8to3_irq;

`ifdef ENC8TO3_EDGE_CAPTURE_EN
  localparam bit EDGE = 1'b1;
`else
  localparam bit EDGE = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] req;
  logic       ack;
  logic [2:0] y;
  logic       valid;
  logic [7:0] pending;
  logic       overrun;

  int n_checks = 0;
  int n_errs   = 0;

  // Reference model state
  logic [7:0] m_pend;
  logic [7:0] m_hist;
  logic       m_valid;
  logic [2:0] m_y;
  logic       m_ovr;

  encoder8to3_irq dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .ack     (ack),
    .y       (y),
    .valid   (valid),
    .pending (pending),
    .overrun (overrun)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pend  = 8'h00;
    m_hist  = 8'h00;
    m_valid = 1'b0;
    m_y     = 3'd0;
    m_ovr   = 1'b0;
  endtask

  function automatic int highest(input logic [7:0] v);
    for (int i = 7; i >= 0; i--) if (v[i]) return i;
    return 0;
  endfunction

  // One clock edge of the event-level behaviour
  task automatic model_step();
    logic [7:0] events;
    logic [7:0] nxt;
    if (!rst_n) begin
      model_reset();
      return;
    end
    events = EDGE ? (req & ~m_hist) : req;
    m_hist = req;
    if (EDGE && ((events & m_pend) != 8'h00)) m_ovr = 1'b1;
    nxt = m_pend;
    if (m_valid && ack) begin
      nxt[m_y] = 1'b0;
      m_valid  = 1'b0;
    end else if (!m_valid && (m_pend != 8'h00)) begin
      m_y     = 3'(highest(m_pend));
      m_valid = 1'b1;
    end
    m_pend = nxt | events;
  endtask

  function automatic logic [12:0] m_out();
    return {m_y, m_valid, m_pend, m_ovr};
  endfunction

  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 8'hFF;
    ack   = 1'b0;
    model_reset();
    #2;
    n_checks++;
    if ({y, valid, pending, overrun} !== 13'h0) begin
      n_errs++;
      $display("FAIL reset_async: got y=%0d valid=%0b pending=%h overrun=%0b need all zero",
               y, valid, pending, overrun);
    end
    cycle();
    cycle();
    n_checks++;
    if ({y, valid, pending, overrun} !== 13'h0) begin
      n_errs++;
      $display("FAIL reset_held: got y=%0d valid=%0b pending=%h overrun=%0b need all zero",
               y, valid, pending, overrun);
    end
    @(negedge clk);
    req   = 8'h00;
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if ({y, valid, pending, overrun} !== m_out()) begin
      n_errs++;
      $display("FAIL reset_release: got %h need %h", {y, valid, pending, overrun}, m_out());
    end
  endtask

  task automatic test_single();
    req = 8'h10;
    cycle();
    req = 8'h00;
    n_checks++;
    if (pending !== 8'h10 || valid !== 1'b0) begin
      n_errs++;
      $display("FAIL single_capture: got pending=%h valid=%0b need pending=10 valid=0", pending, valid);
    end
    cycle();
    n_checks++;
    if (y !== 3'd4 || valid !== 1'b1) begin
      n_errs++;
      $display("FAIL single_grant: got y=%0d valid=%0b need y=4 valid=1", y, valid);
    end
    for (int i = 0; i < 20; i++) begin
      cycle();
      n_checks++;
      if (y !== 3'd4 || valid !== 1'b1 || {y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL single_hold[%0d]: got y=%0d valid=%0b pending=%h need y=4 valid=1 pending=%h",
                 i, y, valid, pending, m_pend);
      end
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || pending !== 8'h00) begin
      n_errs++;
      $display("FAIL single_ack: got valid=%0b pending=%h need valid=0 pending=00", valid, pending);
    end
  endtask

  task automatic test_priority();
    logic [11:0] seq;
    int          n_grant;
    int          n_high;
    logic        prev_v;
    seq     = '0;
    n_grant = 0;
    n_high  = 0;
    prev_v  = valid;
    ack     = 1'b1;
    req     = 8'hA5;
    cycle();
    req = 8'h00;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if ({y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL priority_model[%0d]: got %h need %h", i, {y, valid, pending, overrun}, m_out());
      end
      if (valid) n_high++;
      if (valid && !prev_v) begin
        seq = {seq[8:0], y};
        n_grant++;
      end
      prev_v = valid;
    end
    ack = 1'b0;
    n_checks++;
    if (seq !== {3'd7, 3'd5, 3'd2, 3'd0} || n_grant != 4 || n_high != 4) begin
      n_errs++;
      $display("FAIL priority_order: got seq=%h grants=%0d high=%0d need seq=%h grants=4 high=4",
               seq, n_grant, n_high, {3'd7, 3'd5, 3'd2, 3'd0});
    end
    n_checks++;
    if (pending !== 8'h00) begin
      n_errs++;
      $display("FAIL priority_drain: got pending=%h need 00", pending);
    end
  endtask

  task automatic test_grant_lock();
    req = 8'h04;
    cycle();
    req = 8'h00;
    cycle();
    req = 8'h40;
    cycle();
    req = 8'h00;
    n_checks++;
    if (y !== 3'd2 || valid !== 1'b1 || pending !== 8'h44) begin
      n_errs++;
      $display("FAIL lock_new_high: got y=%0d valid=%0b pending=%h need y=2 valid=1 pending=44",
               y, valid, pending);
    end
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if (y !== 3'd2 || {y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL lock_hold[%0d]: got y=%0d need y=2", i, y);
      end
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || pending !== 8'h40) begin
      n_errs++;
      $display("FAIL lock_ack: got valid=%0b pending=%h need valid=0 pending=40", valid, pending);
    end
    cycle();
    n_checks++;
    if (y !== 3'd6 || valid !== 1'b1) begin
      n_errs++;
      $display("FAIL lock_next: got y=%0d valid=%0b need y=6 valid=1", y, valid);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
    // Re-request index 2 on the very edge that acknowledges it
    req = 8'h04;
    cycle();
    req = 8'h00;
    cycle();
    req = 8'h04;
    ack = 1'b1;
    cycle();
    req = 8'h00;
    ack = 1'b0;
    n_checks++;
    if (pending[2] !== 1'b1 || overrun !== EDGE || valid !== 1'b0) begin
      n_errs++;
      $display("FAIL same_edge_set_clr: got pending=%h overrun=%0b valid=%0b need pending[2]=1 overrun=%0b valid=0",
               pending, overrun, valid, EDGE);
    end
    cycle();
    n_checks++;
    if (y !== 3'd2 || valid !== 1'b1) begin
      n_errs++;
      $display("FAIL same_edge_regrant: got y=%0d valid=%0b need y=2 valid=1", y, valid);
    end
    ack = 1'b1;
    cycle();
    ack = 1'b0;
  endtask

  task automatic test_hold();
    int   n_grant;
    logic prev_v;
    n_grant = 0;
    prev_v  = valid;
    ack     = 1'b1;
    req     = 8'h08;
    for (int i = 0; i < 10; i++) begin
      cycle();
      n_checks++;
      if ({y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL hold_model[%0d]: got %h need %h", i, {y, valid, pending, overrun}, m_out());
      end
      if (valid && !prev_v) begin
        n_grant++;
        n_checks++;
        if (y !== 3'd3) begin
          n_errs++;
          $display("FAIL hold_index: got y=%0d need 3", y);
        end
      end
      prev_v = valid;
    end
    n_checks++;
    if (n_grant != (EDGE ? 1 : 5)) begin
      n_errs++;
      $display("FAIL hold_grants: got %0d need %0d", n_grant, EDGE ? 1 : 5);
    end
    req = 8'h00;
    repeat (4) cycle();
    ack = 1'b0;
    n_checks++;
    if (pending !== 8'h00 || valid !== 1'b0) begin
      n_errs++;
      $display("FAIL hold_drain: got pending=%h valid=%0b need pending=00 valid=0", pending, valid);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      req = ($urandom_range(0, 2) == 0) ? 8'($urandom) : 8'h00;
      ack = 1'($urandom_range(0, 1));
      cycle();
      n_checks++;
      if ({y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL random[%0d]: got y=%0d v=%0b p=%h o=%0b need y=%0d v=%0b p=%h o=%0b",
                 i, y, valid, pending, overrun, m_y, m_valid, m_pend, m_ovr);
      end
    end
    req = 8'h00;
    ack = 1'b1;
    repeat (20) cycle();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid_grant();
    logic [23:0] seq;
    int          n_grant;
    logic        prev_v;
    req = 8'h02;
    cycle();
    req = 8'h00;
    cycle();
    #2;
    rst_n = 1'b0;
    req   = 8'hFF;
    model_reset();
    #1;
    n_checks++;
    if ({y, valid, pending, overrun} !== 13'h0) begin
      n_errs++;
      $display("FAIL reset_mid_grant: got y=%0d valid=%0b pending=%h overrun=%0b need all zero",
               y, valid, pending, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cycle();
    req = 8'h00;
    ack = 1'b1;
    n_checks++;
    if (pending !== 8'hFF || valid !== 1'b0) begin
      n_errs++;
      $display("FAIL held_req_capture: got pending=%h valid=%0b need pending=ff valid=0", pending, valid);
    end
    seq     = '0;
    n_grant = 0;
    prev_v  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_checks++;
      if ({y, valid, pending, overrun} !== m_out()) begin
        n_errs++;
        $display("FAIL all8_model[%0d]: got %h need %h", i, {y, valid, pending, overrun}, m_out());
      end
      if (valid && !prev_v) begin
        seq = {seq[20:0], y};
        n_grant++;
      end
      prev_v = valid;
    end
    ack = 1'b0;
    n_checks++;
    if (seq !== {3'd7, 3'd6, 3'd5, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0} || n_grant != 8 ||
        pending !== 8'h00 || valid !== 1'b0) begin
      n_errs++;
      $display("FAIL all8_order: got seq=%h grants=%0d pending=%h valid=%0b need seq=fac688 grants=8 pending=00 valid=0",
               seq, n_grant, pending, valid);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_priority();
    test_grant_lock();
    test_hold();
    test_random();
    test_reset_mid_grant();
    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
